// File: rtl/temporizador_mef.sv
// temporizador_mef: timing controller for the coffee-machine state machine.
// Watches the external state code and restarts a one-second time base on
// every state change. It issues one TIMER or TIMER_2S pulse per timed visit
// and drives the heating progress bar.
module temporizador_mef #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned T_ESCOLHA   = 10,
  parameter int unsigned T_PAGAMENTO = 15,
  parameter int unsigned T_ERRO      = 3,
  parameter int unsigned T_PRESS     = 2,
  parameter int unsigned T_AQUEC     = 10,
  parameter int unsigned T_PRONTO    = 5
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [2:0] ESTADO,
  output logic       TIMER,
  output logic       TIMER_2S,
  output logic [5:0] SEGUNDOS,
  output logic [9:0] LEDS
);

  typedef enum logic [2:0] {
    ESPERANDO     = 3'b000,
    ESCOLHENDO    = 3'b001,
    SENSORES      = 3'b010,
    PAGAMENTO     = 3'b011,
    ERRO_VALOR    = 3'b100,
    PRESSURIZACAO = 3'b101,
    AQUECIMENTO   = 3'b110,
    PRONTO        = 3'b111
  } estado_e;

  // Progress period is computed in 64 bits so large TICK_DIV cannot overflow.
  localparam logic [63:0]  PROG_DIV  = (64'(T_AQUEC) * 64'(TICK_DIV)) / 64'd10;
  localparam int unsigned  PW        = (PROG_DIV > 64'd1) ? $clog2(PROG_DIV) : 1;
  localparam logic [PW-1:0] PROG_LAST = PW'(PROG_DIV - 64'd1);
  localparam logic [31:0]  TICK_LAST = 32'(TICK_DIV - 1);

  estado_e       estado_cur;
  estado_e       estado_ant_q, estado_ant_d;
  logic [31:0]   presc_q, presc_d;
  logic [5:0]    seg_q, seg_d;
  logic          fired_q, fired_d;
  logic [PW-1:0] prog_q, prog_d;
  logic [9:0]    leds_q, leds_d;
  logic          timer_q, timer_d;
  logic          timer2s_q, timer2s_d;

  logic          change;
  logic          tick;
  logic          prog_wrap;
  logic          timed;
  logic          is_press;
  logic [5:0]    limit;

  assign estado_cur = estado_e'(ESTADO);
  assign change     = (estado_cur != estado_ant_q);
  assign tick       = (presc_q == TICK_LAST);
  assign prog_wrap  = (prog_q == PROG_LAST);

  // Per-state timeout limit and which pulse ends the state.
  always_comb begin
    timed    = 1'b1;
    is_press = 1'b0;
    limit    = '0;
    case (estado_cur)
      ESCOLHENDO:    limit = 6'(T_ESCOLHA);
      PAGAMENTO:     limit = 6'(T_PAGAMENTO);
      ERRO_VALOR:    limit = 6'(T_ERRO);
      PRESSURIZACAO: begin
        limit    = 6'(T_PRESS);
        is_press = 1'b1;
      end
      AQUECIMENTO:   limit = 6'(T_AQUEC);
      PRONTO:        limit = 6'(T_PRONTO);
      default:       timed = 1'b0;
    endcase
  end

  // Time base, timeout pulse and progress bar next-state logic.
  always_comb begin
    estado_ant_d = estado_cur;
    presc_d      = presc_q;
    seg_d        = seg_q;
    fired_d      = fired_q;
    prog_d       = '0;
    leds_d       = '0;
    timer_d      = 1'b0;
    timer2s_d    = 1'b0;
    if (change) begin
      // A state change restarts everything and suppresses any pulse due now.
      presc_d = '0;
      seg_d   = '0;
      fired_d = 1'b0;
    end else begin
      presc_d = tick ? '0 : presc_q + 32'd1;
      if (tick && (seg_q != 6'd63)) begin
        seg_d = seg_q + 6'd1;
      end
      // The pulse follows the cycle in which SEGUNDOS first shows the limit;
      // fired blocks repeats while the state code is held.
      if (timed && !fired_q && (seg_q == limit)) begin
        fired_d = 1'b1;
        if (is_press) begin
          timer2s_d = 1'b1;
        end else begin
          timer_d = 1'b1;
        end
      end
      case (estado_cur)
        AQUECIMENTO: begin
          prog_d = prog_wrap ? '0 : prog_q + PW'(1);
          leds_d = prog_wrap ? {leds_q[8:0], 1'b1} : leds_q;
        end
        PRONTO:  leds_d = '1;
        default: leds_d = '0;
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      estado_ant_q <= ESPERANDO;
      presc_q      <= '0;
      seg_q        <= '0;
      fired_q      <= 1'b0;
      prog_q       <= '0;
      leds_q       <= '0;
      timer_q      <= 1'b0;
      timer2s_q    <= 1'b0;
    end else begin
      estado_ant_q <= estado_ant_d;
      presc_q      <= presc_d;
      seg_q        <= seg_d;
      fired_q      <= fired_d;
      prog_q       <= prog_d;
      leds_q       <= leds_d;
      timer_q      <= timer_d;
      timer2s_q    <= timer2s_d;
    end
  end

  assign TIMER    = timer_q;
  assign TIMER_2S = timer2s_q;
  assign SEGUNDOS = seg_q;
  assign LEDS     = leds_q;

endmodule

// File: tb/tb_temporizador_mef.sv
// Bench for temporizador_mef: directed scenarios followed by random state
// sequences, compared every cycle against a visit-age reference model.
module tb_temporizador_mef;

  localparam int unsigned TD  = 4;
  localparam int unsigned TE  = 10;
  localparam int unsigned TP  = 15;
  localparam int unsigned TR  = 3;
  localparam int unsigned TPR = 2;
  localparam int unsigned TA  = 10;
  localparam int unsigned TPN = 5;
  localparam int unsigned PD  = TA * TD / 10;

  logic       CLK;
  logic       RESET_N;
  logic [2:0] ESTADO;
  logic       TIMER;
  logic       TIMER_2S;
  logic [5:0] SEGUNDOS;
  logic [9:0] LEDS;

  int checks = 0;
  int passed = 0;

  // Reference model: the last sampled state code and the number of edges
  // since that visit began (0 at the edge that first sampled it).
  logic [2:0]  m_prev;
  int unsigned m_n;

  temporizador_mef #(
    .TICK_DIV   (TD),
    .T_ESCOLHA  (TE),
    .T_PAGAMENTO(TP),
    .T_ERRO     (TR),
    .T_PRESS    (TPR),
    .T_AQUEC    (TA),
    .T_PRONTO   (TPN)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .ESTADO  (ESTADO),
    .TIMER   (TIMER),
    .TIMER_2S(TIMER_2S),
    .SEGUNDOS(SEGUNDOS),
    .LEDS    (LEDS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int unsigned lim(input logic [2:0] s);
    case (s)
      3'd1:    return TE;
      3'd3:    return TP;
      3'd4:    return TR;
      3'd6:    return TA;
      3'd7:    return TPN;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_timer();
    return (lim(m_prev) != 0) && (m_n == lim(m_prev) * TD + 1);
  endfunction

  function automatic logic exp_t2s();
    return (m_prev == 3'd5) && (m_n == TPR * TD + 1);
  endfunction

  function automatic logic [5:0] exp_seg();
    int unsigned s;
    s = m_n / TD;
    if (s > 63) s = 63;
    return 6'(s);
  endfunction

  function automatic logic [9:0] exp_leds();
    int unsigned k;
    if (m_prev == 3'd6) begin
      k = m_n / PD;
      if (k > 10) k = 10;
      return 10'((1 << k) - 1);
    end
    if (m_prev == 3'd7) return (m_n >= 1) ? 10'h3FF : 10'h000;
    return 10'h000;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".timer"}, 32'(TIMER), 32'(exp_timer()));
    check({tag, ".timer2s"}, 32'(TIMER_2S), 32'(exp_t2s()));
    check({tag, ".seg"}, 32'(SEGUNDOS), 32'(exp_seg()));
    check({tag, ".leds"}, 32'(LEDS), 32'(exp_leds()));
    check({tag, ".excl"}, 32'(TIMER & TIMER_2S), 32'd0);
  endtask

  // One clock: drive the state code, advance the model at the edge, check.
  task automatic step(input logic [2:0] s, output logic t, output logic t2);
    ESTADO = s;
    @(posedge CLK);
    if (!RESET_N) begin
      m_prev = 3'd0;
      m_n    = 0;
    end else if (ESTADO != m_prev) begin
      m_prev = ESTADO;
      m_n    = 0;
    end else if (m_n < 100000) begin
      m_n++;
    end
    @(negedge CLK);
    check_all("cyc");
    t  = TIMER;
    t2 = TIMER_2S;
  endtask

  // Hold a state code; verify pulse count, edge index and SEGUNDOS at pulse.
  task automatic hold(input logic [2:0] s, input int unsigned cyc,
                      input int exp_tmr, input int exp_t2s, input string tag);
    int          first_t  = -1;
    int          first_t2 = -1;
    int unsigned nt       = 0;
    int unsigned nt2      = 0;
    logic [5:0]  seg_at   = '0;
    logic        t, t2;
    for (int unsigned i = 0; i < cyc; i++) begin
      step(s, t, t2);
      if (t) begin
        nt++;
        if (first_t < 0) begin
          first_t = int'(i);
          seg_at  = SEGUNDOS;
        end
      end
      if (t2) begin
        nt2++;
        if (first_t2 < 0) begin
          first_t2 = int'(i);
          seg_at   = SEGUNDOS;
        end
      end
    end
    if (exp_tmr >= 0) begin
      check({tag, ".tmr_count"}, nt, 1);
      check({tag, ".tmr_edge"}, first_t, exp_tmr);
      check({tag, ".tmr_seg"}, 32'(seg_at), exp_tmr / int'(TD));
    end else begin
      check({tag, ".tmr_none"}, nt, 0);
    end
    if (exp_t2s >= 0) begin
      check({tag, ".t2s_count"}, nt2, 1);
      check({tag, ".t2s_edge"}, first_t2, exp_t2s);
      check({tag, ".t2s_seg"}, 32'(seg_at), exp_t2s / int'(TD));
    end else begin
      check({tag, ".t2s_none"}, nt2, 0);
    end
  endtask

  // Drop reset between edges, check outputs cleared at once, then release.
  task automatic async_reset(input logic [2:0] s, input int unsigned delay, input int unsigned edges);
    logic t, t2;
    #(delay);
    RESET_N = 1'b0;
    #1;
    m_prev = 3'd0;
    m_n    = 0;
    check_all("async_rst");
    for (int unsigned i = 0; i < edges; i++) step(s, t, t2);
    RESET_N = 1'b1;
  endtask

  initial begin
    logic        t, t2;
    logic [2:0]  rs;
    int unsigned rd;

    RESET_N = 1'b0;
    ESTADO  = 3'd0;
    m_prev  = 3'd0;
    m_n     = 0;
    repeat (3) @(negedge CLK);
    check_all("reset");
    RESET_N = 1'b1;

    hold(3'd0, 5, -1, -1, "idle");
    hold(3'd1, 60, 41, -1, "escolha");
    hold(3'd3, 30, -1, -1, "pagamento");
    hold(3'd4, 20, 13, -1, "erro");
    hold(3'd5, 20, -1, 9, "press");
    hold(3'd0, 2, -1, -1, "gap");
    hold(3'd5, 9, -1, -1, "press_abort");
    hold(3'd6, 45, 41, -1, "aquec");
    check("aquec.leds_full", 32'(LEDS), 32'h3FF);
    hold(3'd7, 3, -1, -1, "pronto");
    check("pronto.leds", 32'(LEDS), 32'h3FF);
    hold(3'd0, 2, -1, -1, "back_idle");
    check("idle.leds", 32'(LEDS), 32'h0);
    hold(3'd0, 300, -1, -1, "untimed0");
    check("untimed0.sat", 32'(SEGUNDOS), 32'd63);
    hold(3'd2, 300, -1, -1, "untimed2");
    check("untimed2.sat", 32'(SEGUNDOS), 32'd63);

    hold(3'd6, 20, -1, -1, "aquec_pre_rst");
    async_reset(3'd6, 3, 2);
    hold(3'd6, 45, 41, -1, "post_rst");

    for (int unsigned it = 0; it < 40; it++) begin
      rs = 3'($urandom_range(0, 7));
      rd = $urandom_range(1, 70);
      if ($urandom_range(0, 7) == 0) async_reset(rs, $urandom_range(1, 3), $urandom_range(1, 3));
      for (int unsigned c = 0; c < rd; c++) step(rs, t, t2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
